// File: rtl/multi_pulse_synchro.sv
// N-channel event synchroniser: resynchronises async event inputs and emits fixed-width pulses with per-channel queuing.
// Define MPS_OVERFLOW_ERR_EN to add sticky overflow flags (err_o) with per-channel clear (err_clr_i).
module multi_pulse_synchro #(
    parameter int NB_CHANNELS = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_WIDTH = 2,
    parameter int PENDING_MAX = 3,
    parameter int TOGGLE_MODE = 0
) (
    input  logic                   aclk,
    input  logic                   arstn,
    input  logic [NB_CHANNELS-1:0] async_i,
    output logic [NB_CHANNELS-1:0] tvalid_o,
    output logic [NB_CHANNELS-1:0] busy_o
`ifdef MPS_OVERFLOW_ERR_EN
    ,
    output logic [NB_CHANNELS-1:0] err_o,
    input  logic [NB_CHANNELS-1:0] err_clr_i
`endif
);
    localparam int PCW = $clog2(PENDING_MAX + 1);
    localparam int CW  = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam logic [PCW-1:0] PMAX     = PCW'(PENDING_MAX);
    localparam logic [CW-1:0]  CNT_INIT = CW'(PULSE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    logic [NB_CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [NB_CHANNELS-1:0] prev_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic [NB_CHANNELS-1:0] edge_w;
    logic [NB_CHANNELS-1:0] event_w;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q  <= '0;
            prime_q <= '0;
        end else begin
            sync_q[0] <= async_i;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q  <= sync_q[SYNC_STAGES-1];
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    if (TOGGLE_MODE != 0) begin : g_toggle
        assign edge_w = sync_q[SYNC_STAGES-1] ^ prev_q;
    end else begin : g_rise
        assign edge_w = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Edges are ignored until prev holds a real post-reset sample, so levels present at reset are not events.
    assign event_w = prime_q[SYNC_STAGES] ? edge_w : '0;

    for (genvar c = 0; c < NB_CHANNELS; c++) begin : g_ch
        state_t         state_q, state_d;
        logic [CW-1:0]  cnt_q, cnt_d;
        logic [PCW-1:0] pend_q, pend_d;

        always_ff @(posedge aclk or negedge arstn) begin
            if (!arstn) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pend_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pend_d  = pend_q;
            unique case (state_q)
                IDLE: begin
                    if (event_w[c]) begin
                        state_d = PULSE;
                        cnt_d   = CNT_INIT;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) state_d = GAP;
                    else             cnt_d   = cnt_q - 1'b1;
                    if (event_w[c] && pend_q != PMAX) pend_d = pend_q + 1'b1;
                end
                GAP: begin
                    if (pend_q != '0 || event_w[c]) begin
                        state_d = PULSE;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                    // A same-cycle event takes the slot freed by the dequeue.
                    if (pend_q != '0 && !event_w[c]) pend_d = pend_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        assign tvalid_o[c] = (state_q == PULSE);
        assign busy_o[c]   = (state_q != IDLE) || (pend_q != '0);

`ifdef MPS_OVERFLOW_ERR_EN
        logic drop_w;
        logic err_q;
        assign drop_w = (state_q == PULSE) && event_w[c] && (pend_q == PMAX);

        always_ff @(posedge aclk or negedge arstn) begin
            if (!arstn)            err_q <= 1'b0;
            else if (drop_w)       err_q <= 1'b1;
            else if (err_clr_i[c]) err_q <= 1'b0;
        end

        assign err_o[c] = err_q;
`endif
    end

endmodule
